// File: rtl/gpio_in_filter.sv
`default_nettype none
// ============================================================================
// Module   : gpio_in_filter
// Purpose  : Per-bit GPIO input glitch filter with registered rise/fall
//            pulses and sticky edge status. Optional two-flop input
//            synchronizer enabled by defining GPIO_IN_FILTER_SYNC_EN.
// Revision : 1.0
// ============================================================================
module gpio_in_filter #(
  parameter int N_GPIO        = 32,
  parameter int FILTER_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_GPIO-1:0] gpio_i,
  input  logic [N_GPIO-1:0] filter_en_i,
  input  logic              clr_i,
  output logic [N_GPIO-1:0] gpio_o,
  output logic [N_GPIO-1:0] rise_o,
  output logic [N_GPIO-1:0] fall_o,
  output logic [N_GPIO-1:0] status_rise_o,
  output logic [N_GPIO-1:0] status_fall_o
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [N_GPIO-1:0] samp;
  logic [N_GPIO-1:0] gpio_next;
  logic [N_GPIO-1:0] rise_next;
  logic [N_GPIO-1:0] fall_next;

`ifdef GPIO_IN_FILTER_SYNC_EN
  logic [N_GPIO-1:0] sync_meta;
  logic [N_GPIO-1:0] sync_stage;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_meta  <= '0;
      sync_stage <= '0;
    end else begin
      sync_meta  <= gpio_i;
      sync_stage <= sync_meta;
    end
  end

  assign samp = sync_stage;
`else
  assign samp = gpio_i;
`endif

  for (genvar i = 0; i < N_GPIO; i++) begin : g_bit
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             bit_next;

    // The counter only advances while the sample disagrees with the output;
    // it saturates at CNT_MAX because reaching it flips the output instead.
    always_comb begin
      cnt_next = '0;
      bit_next = gpio_o[i];
      if (!filter_en_i[i]) begin
        bit_next = samp[i];
      end else if (samp[i] != gpio_o[i]) begin
        if (cnt == CNT_MAX) begin
          bit_next = samp[i];
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end

    assign gpio_next[i] = bit_next;
  end

  assign rise_next = gpio_next & ~gpio_o;
  assign fall_next = ~gpio_next & gpio_o;

  // A new edge on the clearing cycle wins over the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gpio_o        <= '0;
      rise_o        <= '0;
      fall_o        <= '0;
      status_rise_o <= '0;
      status_fall_o <= '0;
    end else begin
      gpio_o        <= gpio_next;
      rise_o        <= rise_next;
      fall_o        <= fall_next;
      status_rise_o <= (clr_i ? '0 : status_rise_o) | rise_next;
      status_fall_o <= (clr_i ? '0 : status_fall_o) | fall_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/gpio_in_filter.md
GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

Interface
REQ-001 The block SHALL have parameter N_GPIO, default 32: number of GPIO bits.
REQ-002 The block SHALL have parameter FILTER_CYCLES, default 16: consecutive cycles a differing input must hold before it is accepted; legal range 1..65535.
REQ-003 The block SHALL have port clk_i, input, 1: the single clock; all state updates on its posedge.
REQ-004 The block SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port gpio_i, input, N_GPIO: raw pad-side input; may be asynchronous to clk_i.
REQ-006 The block SHALL have port filter_en_i, input, N_GPIO: per-bit filter enable; 0 selects pass-through.
REQ-007 The block SHALL have port clr_i, input, 1: one-cycle pulse that clears both sticky status vectors.
REQ-008 The block SHALL have port gpio_o, output, N_GPIO: filtered input value.
REQ-009 The block SHALL have port rise_o, output, N_GPIO: one-cycle pulse per bit on a 0->1 change of gpio_o.
REQ-010 The block SHALL have port fall_o, output, N_GPIO: one-cycle pulse per bit on a 1->0 change of gpio_o.
REQ-011 The block SHALL have port status_rise_o, output, N_GPIO: sticky OR of rise_o since the last clear.
REQ-012 The block SHALL have port status_fall_o, output, N_GPIO: sticky OR of fall_o since the last clear.

Function
REQ-013 The block SHALL derive an internal sampled vector s from gpio_i, as set by REQ-033/REQ-034.
REQ-014 Each bit SHALL own a stability counter of width max(1, $clog2(FILTER_CYCLES)) bits.
REQ-015 Filtered bit, s[i] == gpio_o[i]: counter[i] <= 0; gpio_o[i] holds.
REQ-016 Filtered bit, s[i] != gpio_o[i], counter[i] < FILTER_CYCLES-1: counter[i] increments by 1.
REQ-017 Filtered bit, s[i] != gpio_o[i], counter[i] == FILTER_CYCLES-1: gpio_o[i] <= s[i] and counter[i] <= 0 on the same edge.
REQ-018 A pulse on s[i] shorter than FILTER_CYCLES cycles SHALL leave gpio_o[i] unchanged, and the counter SHALL restart from 0 on the next differing cycle.
REQ-019 The counter SHALL never wrap: the maximum value is FILTER_CYCLES-1.
REQ-020 Unfiltered bit (filter_en_i[i]=0): gpio_o[i] <= s[i] every cycle; counter[i] <= 0.
REQ-021 If filter_en_i[i] deasserts mid-count, the count SHALL be discarded and the bit SHALL pass through on the next edge.
REQ-022 If filter_en_i[i] asserts, counting SHALL start from 0.
REQ-023 rise_o[i] and fall_o[i] SHALL be registered and assert on the same edge that gpio_o[i] changes, for exactly one cycle; both never assert together.
REQ-024 Independent bits SHALL update independently; simultaneous changes on multiple bits SHALL all pulse in the same cycle.
REQ-025 Status update: status_x <= (clr_i ? 0 : status_x) | x_o_next, for x in {rise, fall}; an event coincident with clr_i SHALL survive the clear.
REQ-026 Latency, filtered bit, with synchronizer: gpio_i stable from sampling edge E0 => gpio_o updates at edge E(FILTER_CYCLES+1).
REQ-027 Latency, unfiltered bit, with synchronizer: gpio_o updates at edge E2.

Reset
REQ-028 While rst_i=1 at a posedge, gpio_o, rise_o, fall_o, status_rise_o and status_fall_o SHALL be 0.
REQ-029 While rst_i=1 at a posedge, all counters and synchronizer flops SHALL be 0.
REQ-030 Reset asserted mid-count SHALL discard the count.
REQ-031 No pulse SHALL be generated by the reset itself.
REQ-032 After reset release with gpio_i=all-ones, each bit SHALL see a normal 0->1 transition with the REQ-026/027 latency and a rise_o pulse.

Configuration
REQ-033 With macro GPIO_IN_FILTER_SYNC_EN defined, s SHALL be the output of a two-flop synchronizer per bit, adding 2 cycles of latency.
REQ-034 With GPIO_IN_FILTER_SYNC_EN undefined, s = gpio_i directly; every latency in REQ-026/027/VER SHALL be reduced by 2 edges (filtered: E(FILTER_CYCLES-1), unfiltered: E0).

Verification (FILTER_CYCLES=4, N_GPIO=32, GPIO_IN_FILTER_SYNC_EN defined)
REQ-035 filter_en_i=all-ones, gpio_i[0] 0->1 before E0, held -> gpio_o[0]=1 and rise_o[0] pulse at E5 only; status_rise_o[0]=1 thereafter.
REQ-036 gpio_i[3] high for 3 cycles then low -> gpio_o[3], rise_o[3] and status stay 0 for 20 cycles.
REQ-037 filter_en_i[7]=0, gpio_i[7] toggles every cycle -> gpio_o[7] follows with 2-edge delay; rise_o[7]/fall_o[7] alternate every cycle.
REQ-038 Status bit set, then clr_i pulsed on the same edge as a new fall_o[1] -> status_fall_o[1] stays 1 and other status bits go to 0.
REQ-039 gpio_i=32'hFFFF_FFFF with rst_i asserted 2 cycles into counting -> all outputs 0 during reset; after release, gpio_o=32'hFFFF_FFFF at E5 with a full rise_o vector pulse.
